// File: rtl/fmap_load_ctrl.sv
// Load sequencer for the column-to-matrix builder: clears the builder, issues ceil(m*n/4)
// word reads and forwards the returned words. Define FMAP_LOAD_ERR_EN to reject illegal sizes.
module fmap_load_ctrl #(
   parameter int DIM     = 32,
   parameter int AW      = 16,
   parameter int MAX_OUT = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [AW-1:0]        cmd_addr,
   input  logic [$clog2(DIM):0] cmd_m,
   input  logic [$clog2(DIM):0] cmd_n,
   output logic                 mem_req_valid,
   input  logic                 mem_req_ready,
   output logic [AW-1:0]        mem_req_addr,
   input  logic                 mem_rsp_valid,
   input  logic [31:0]          mem_rsp_data,
   output logic                 bld_rst_n,
   output logic                 bld_en,
   output logic [31:0]          bld_data,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int DW = $clog2(DIM) + 1;
   localparam int WW = $clog2(DIM * DIM) + 1;
   localparam int PW = 2 * DW + 1;
   localparam int OW = $clog2(MAX_OUT + 1);

   typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, FIN} state_t;

   state_t        state;
   logic [AW-1:0] base;
   logic [WW-1:0] words;
   logic [WW-1:0] issued;
   logic [WW-1:0] received;
   logic [OW-1:0] outstanding;

   logic [PW-1:0] prod;
   logic [WW-1:0] words_cmd;
   logic [WW-1:0] issued_nx;
   logic [WW-1:0] received_nx;
   logic [OW-1:0] outstanding_nx;
   logic          req_acc;
   logic          rsp_cnt;
   logic          rsp_dec;
   logic          cmd_bad;

`ifdef FMAP_LOAD_ERR_EN
   logic bad_q;
   assign cmd_bad = (cmd_m == '0) || (cmd_n == '0) ||
                    (cmd_m > DW'(DIM)) || (cmd_n > DW'(DIM));
`else
   assign cmd_bad = 1'b0;
   assign err     = 1'b0;
`endif

   always_comb begin
      // NOTE: every always_comb output is assigned on all paths, starting from a default, so no latch is inferred.
      prod           = PW'(cmd_m) * PW'(cmd_n);
      words_cmd      = WW'((prod + PW'(3)) >> 2);
      req_acc        = mem_req_valid & mem_req_ready;
      rsp_cnt        = mem_rsp_valid & ((state == FETCH) || (state == DRAIN));
      // A stray response with nothing outstanding must not wrap the counter.
      rsp_dec        = rsp_cnt & (outstanding != '0);
      issued_nx      = issued + WW'(req_acc);
      received_nx    = received + WW'(rsp_cnt);
      outstanding_nx = outstanding;
      unique case ({req_acc, rsp_dec})
         2'b10:   outstanding_nx = outstanding + OW'(1);
         2'b01:   outstanding_nx = outstanding - OW'(1);
         default: outstanding_nx = outstanding;
      endcase
   end

   // NOTE: all state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         base          <= '0;
         words         <= '0;
         issued        <= '0;
         received      <= '0;
         outstanding   <= '0;
         cmd_ready     <= 1'b1;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= '0;
         bld_rst_n     <= 1'b1;
         bld_en        <= 1'b0;
         bld_data      <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
`ifdef FMAP_LOAD_ERR_EN
         err           <= 1'b0;
         bad_q         <= 1'b0;
`endif
      end else begin
         done   <= 1'b0;
         bld_en <= (state != IDLE) & mem_rsp_valid;
         if ((state != IDLE) && mem_rsp_valid) begin
            bld_data <= mem_rsp_data;
         end

         unique case (state)
            IDLE: begin
               if (cmd_valid) begin
                  base      <= cmd_addr;
                  words     <= cmd_bad ? '0 : words_cmd;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  bld_rst_n <= 1'b0;
                  state     <= CLEAR;
`ifdef FMAP_LOAD_ERR_EN
                  bad_q     <= cmd_bad;
                  err       <= 1'b0;
`endif
               end
            end

            CLEAR: begin
               bld_rst_n   <= 1'b1;
               issued      <= '0;
               received    <= '0;
               outstanding <= '0;
               if (words == '0) begin
                  state <= FIN;
                  done  <= 1'b1;
`ifdef FMAP_LOAD_ERR_EN
                  err   <= bad_q;
`endif
               end else begin
                  state         <= FETCH;
                  mem_req_valid <= 1'b1;
                  mem_req_addr  <= base;
               end
            end

            FETCH: begin
               issued      <= issued_nx;
               received    <= received_nx;
               outstanding <= outstanding_nx;
               if (issued_nx == words) begin
                  state         <= DRAIN;
                  mem_req_valid <= 1'b0;
               end else begin
                  // An unaccepted request keeps issued and can only lose outstanding, so valid/addr hold.
                  mem_req_valid <= outstanding_nx < OW'(MAX_OUT);
                  mem_req_addr  <= base + AW'(issued_nx);
               end
            end

            DRAIN: begin
               received    <= received_nx;
               outstanding <= outstanding_nx;
               if (received == words) begin
                  state <= FIN;
                  done  <= 1'b1;
               end
            end

            FIN: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end

            default: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fmap_load_ctrl.sv
// Directed + randomized loads of fmap_load_ctrl against a queue-based memory and a
// ceil(m*n/4) reference model; honours FMAP_LOAD_ERR_EN when defined.
module tb_fmap_load_ctrl;

   localparam int DIM     = 32;
   localparam int AW      = 16;
   localparam int MAX_OUT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_addr;
   logic [5:0]  cmd_m;
   logic [5:0]  cmd_n;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [15:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        bld_rst_n;
   logic        bld_en;
   logic [31:0] bld_data;
   logic        busy;
   logic        done;
   logic        err;

   fmap_load_ctrl #(.DIM(DIM), .AW(AW), .MAX_OUT(MAX_OUT)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_addr      (cmd_addr),
      .cmd_m         (cmd_m),
      .cmd_n         (cmd_n),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .bld_rst_n     (bld_rst_n),
      .bld_en        (bld_en),
      .bld_data      (bld_data),
      .busy          (busy),
      .done          (done),
      .err           (err)
   );

   typedef struct {
      logic [15:0] addr;
      int          due;
   } pend_t;

   pend_t       pend[$];
   logic [15:0] req_log[$];
   logic [31:0] bld_log[$];
   int          bld_cyc[$];
   int          rsp_cyc[$];

   int   cyc        = 0;
   int   checks     = 0;
   int   errors     = 0;
   int   lat        = 2;
   int   rdy_prob   = 100;
   int   rdy_limit  = 1 << 30;
   int   low_trig   = -1;
   int   low_cnt    = 0;
   int   hold_until = 0;
   int   acc_total  = 0;
   int   viol       = 0;
   int   max_pend   = 0;
   int   stall_cyc  = 0;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_addr  = '0;
   logic [31:0] salt;

   int          exp_w;
   logic        exp_err;
   logic [15:0] cur_base;
   int          t_acc;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return {a ^ salt[31:16], ~a ^ salt[15:0]};
   endfunction

   // Reference: words = ceil(m*n/4); illegal sizes fetch nothing when checking is enabled.
   function automatic void model(input int m, input int n, output int w, output logic e);
      e = 1'b0;
`ifdef FMAP_LOAD_ERR_EN
      if (m == 0 || n == 0 || m > DIM || n > DIM) e = 1'b1;
`endif
      w = e ? 0 : (m * n + 3) / 4;
   endfunction

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Memory: in-order responses after `lat` cycles, programmable ready, plus bus monitors.
   initial begin
      pend_t p;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         mem_rsp_valid = 1'b0;
         mem_rsp_data  = $urandom;
         if (pend.size() != 0 && pend[0].due <= cyc && cyc >= hold_until) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(pend[0].addr);
            rsp_cyc.push_back(cyc);
            void'(pend.pop_front());
         end
         if (low_trig >= 0 && acc_total >= low_trig) begin
            low_cnt  = 5;
            low_trig = -1;
         end
         if (low_cnt > 0) begin
            mem_req_ready = 1'b0;
            low_cnt--;
         end else begin
            mem_req_ready = (acc_total < rdy_limit) && (int'($urandom_range(99)) < rdy_prob);
         end
         if (rst_n && prev_stall && !(mem_req_valid === 1'b1 && mem_req_addr === prev_addr)) viol++;
         if (rst_n && mem_req_valid && !mem_req_ready) stall_cyc++;
         if (rst_n && mem_req_valid && mem_req_ready) begin
            req_log.push_back(mem_req_addr);
            p.addr = mem_req_addr;
            p.due  = cyc + lat;
            pend.push_back(p);
            acc_total++;
         end
         prev_stall = rst_n && mem_req_valid && !mem_req_ready;
         prev_addr  = mem_req_addr;
         if (pend.size() > max_pend) max_pend = pend.size();
         if (bld_en === 1'b1) begin
            bld_log.push_back(bld_data);
            bld_cyc.push_back(cyc);
         end
      end
   end

   task automatic start_load(input logic [15:0] a, input int m, input int n);
      model(m, n, exp_w, exp_err);
      cur_base = a;
      req_log.delete();
      bld_log.delete();
      bld_cyc.delete();
      rsp_cyc.delete();
      viol      = 0;
      max_pend  = pend.size();
      stall_cyc = 0;
      check("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_m     = 6'(m);
      cmd_n     = 6'(n);
      tick;
      cmd_valid = 1'b0;
      cmd_addr  = 16'($urandom);
      t_acc     = cyc - 1;
      check("clear_bld_rst_n", bld_rst_n, 0);
      check("clear_busy", busy, 1);
      check("clear_cmd_ready", cmd_ready, 0);
      check("clear_err", err, 0);
      tick;
      check("t2_bld_rst_n", bld_rst_n, 1);
      check("t2_req_valid", mem_req_valid, exp_w > 0);
      if (exp_w > 0) check("t2_req_addr", mem_req_addr, a);
   endtask

   task automatic finish_load;
      int n = 0;
      int dc;
      while (done !== 1'b1 && n < 3000) begin
         tick;
         n++;
      end
      cmd_valid = 1'b0;
      check("done_seen", done, 1);
      if (done === 1'b1) begin
         dc = cyc;
         check("done_err", err, exp_err);
         check("fin_cmd_ready", cmd_ready, 0);
         if (exp_w > 0) check("done_after_last_bld", dc, (bld_cyc.size() != 0) ? bld_cyc[$] + 1 : -1);
         else check("done_at_t2", dc, t_acc + 2);
         tick;
         check("idle_cmd_ready", cmd_ready, 1);
         check("idle_busy", busy, 0);
         check("done_pulse", done, 0);
      end
      check("req_count", req_log.size(), exp_w);
      for (int i = 0; i < req_log.size() && i < exp_w; i++)
         check("req_addr", req_log[i], 16'(cur_base + i));
      check("bld_count", bld_log.size(), exp_w);
      for (int i = 0; i < bld_log.size() && i < exp_w; i++)
         check("bld_data", bld_log[i], mem_word(16'(cur_base + i)));
      for (int i = 0; i < bld_cyc.size() && i < rsp_cyc.size(); i++)
         check("bld_latency", bld_cyc[i], rsp_cyc[i] + 1);
      check("req_stable", viol, 0);
      check("max_outstanding", max_pend <= MAX_OUT, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      salt      = $urandom;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_m     = '0;
      cmd_n     = '0;
      tick;
      tick;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_bld_rst_n", bld_rst_n, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_req_valid", mem_req_valid, 0);
      check("rst_bld_en", bld_en, 0);
      check("rst_req_addr", mem_req_addr, 0);
      check("rst_bld_data", bld_data, 0);
      rst_n = 1'b1;
      tick;

      // 4x4 at 0x0100, ready high, latency 2: back-to-back words
      lat = 2; rdy_prob = 100;
      start_load(16'h0100, 4, 4);
      finish_load;
      check("tput_4x4", (bld_cyc.size() == 4) ? bld_cyc[3] - bld_cyc[0] : -1, 3);

      // 3x3 -> 3 words, with a competing command held during the load
      start_load(16'h0200, 3, 3);
      cmd_valid = 1'b1; cmd_addr = 16'hDEAD; cmd_m = 6'd5; cmd_n = 6'd7;
      tick;
      check("busy_cmd_ready", cmd_ready, 0);
      finish_load;

      // 8x8 throughput at latency 2
      start_load(16'h1000, 8, 8);
      finish_load;
      check("tput_8x8", (bld_cyc.size() == 16) ? bld_cyc[15] - bld_cyc[0] : -1, 15);

      // ready low for 5 cycles mid-FETCH
      low_trig = acc_total + 2;
      start_load(16'h0300, 6, 4);
      finish_load;
      check("ready_low_cycles", stall_cyc, 5);

      // responses withheld: stall at MAX_OUT requests, then resume
      hold_until = cyc + 30;
      start_load(16'h0400, 8, 8);
      repeat (20) tick;
      check("stall_req_count", req_log.size(), MAX_OUT);
      check("stall_req_valid", mem_req_valid, 0);
      hold_until = 0;
      finish_load;

      // address wrap
      start_load(16'hFFFE, 4, 4);
      finish_load;

      // reset with two reads outstanding
      rdy_limit  = acc_total + 2;
      hold_until = cyc + 1000;
      start_load(16'h0500, 8, 8);
      repeat (6) tick;
      check("pre_rst_reqs", req_log.size(), 2);
      check("pre_rst_valid", mem_req_valid, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_cmd_ready", cmd_ready, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_req_valid", mem_req_valid, 0);
      check("mid_rst_req_addr", mem_req_addr, 0);
      check("mid_rst_bld_rst_n", bld_rst_n, 1);
      tick;
      rst_n      = 1'b1;
      rdy_limit  = 1 << 30;
      hold_until = 0;
      bld_log.delete();
      repeat (12) tick;
      check("late_rsp_drained", pend.size(), 0);
      check("late_rsp_no_bld", bld_log.size(), 0);
      check("late_no_req", req_log.size(), 2);

      // zero and oversized dimensions
      start_load(16'h0600, 0, 5);
      finish_load;
      start_load(16'h0700, 40, 1);
      finish_load;

      // randomized loads
      for (int k = 0; k < 6; k++) begin
         lat      = $urandom_range(1, 6);
         rdy_prob = $urandom_range(40, 100);
         start_load(16'($urandom), $urandom_range(1, 8), $urandom_range(1, 8));
         finish_load;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fmap_load_ctrl.md
# fmap_load_ctrl

Sequencer for the column-to-matrix builder. It accepts a load command (base word address and an m×n feature-map size) and issues ceil(m·n/4) 32-bit word reads to the on-chip memory port. Each returned word is forwarded to the builder with a one-cycle enable, and completion is reported to the accelerator top-level FSM. Before every load it clears the builder, so the builder's mandatory per-use reset is owned here.

## Interface
- DIM, 32: maximum feature-map dimension; m, n range 1..DIM
- AW, 16: memory word-address width
- MAX_OUT, 4: maximum outstanding memory reads (≥1)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  load command valid
- cmd_ready  out  1  controller idle and able to accept a command
- cmd_addr  in  AW  base word address of the map
- cmd_m, cmd_n  in  $clog2(DIM)+1  map rows and columns
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts the request
- mem_req_addr  out  AW  word address of the request
- mem_rsp_valid  in  1  read data valid; in order; no backpressure
- mem_rsp_data  in  32  read data
- bld_rst_n  out  1  builder clear, active-low
- bld_en  out  1  write strobe to the builder
- bld_data  out  32  word to the builder
- busy  out  1  load in progress
- done  out  1  one-cycle completion pulse
- err  out  1  illegal command flag; see Configuration

## Operation
- States: IDLE, CLEAR, FETCH, DRAIN, FIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch addr, m and n, and compute W=ceil(m·n/4) at width $clog2(DIM·DIM)+1; go to CLEAR.
- CLEAR:
  - bld_rst_n=0 for exactly one cycle; reset the issue, outstanding and received counters.
  - Go to FETCH, or to FIN if W=0.
- FETCH:
  - mem_req_valid=1 while issued<W and outstanding<MAX_OUT.
  - mem_req_addr = base+issued, modulo 2^AW.
  - Once raised, valid and addr are held stable until mem_req_ready.
  - When issued reaches W, go to DRAIN.
- Counter updates:
  - outstanding +1 on each accepted request and −1 on each mem_rsp_valid; it is unchanged when both occur in the same cycle.
  - received +1 per mem_rsp_valid.
- DRAIN: no requests; wait until received==W, then go to FIN.
- FIN: done=1 for one cycle; go to IDLE.
- Builder path (all states except IDLE): bld_en and bld_data are registered copies of mem_rsp_valid and mem_rsp_data.
- Responses arriving in IDLE are ignored: bld_en stays 0.
- busy=1 in CLEAR, FETCH, DRAIN and FIN.
- Reset values of all outputs:
  - cmd_ready=1, bld_rst_n=1.
  - busy, done, err, mem_req_valid and bld_en = 0.
  - mem_req_addr and bld_data = 0.
- Reset mid-load: return to IDLE immediately and clear all counters. In-flight responses that arrive afterwards are dropped.

## Timing
- Command accepted at cycle T.
- T+1: CLEAR, with bld_rst_n=0.
- T+2: first mem_req_valid.
- Response at cycle R → bld_en=1 at R+1.
- Last bld_en at cycle L → done=1 at L+1 (FIN).
- cmd_ready returns high at L+2.
- Throughput: one word per cycle when memory latency ≤ MAX_OUT cycles and ready is held high.
- A command presented while busy is not accepted; cmd_ready=0 for the whole load.

## Configuration
- FMAP_LOAD_ERR_EN defined:
  - Commands with m=0, n=0, m>DIM or n>DIM are still accepted.
  - The controller then goes CLEAR→FIN with no memory requests.
  - err=1 in the FIN cycle, alongside done.
  - err is cleared when the next command is accepted.
- FMAP_LOAD_ERR_EN undefined:
  - err is tied to 0; dimensions are used unchecked.
  - m·n=0 gives W=0: CLEAR→FIN with no requests.
  - Oversized dimensions still fetch W words; the builder's contents are then unspecified.

## Test plan
- 4×4 map at addr 0x0100, ready=1, latency 2 → requests to 0x0100..0x0103; exactly 4 bld_en with matching data; bld_rst_n low at T+1; done one cycle after the last bld_en.
- 3×3 map → W=3: exactly 3 requests and 3 bld_en, then done; cmd_ready high 2 cycles after the last bld_en.
- mem_req_ready held low for 5 cycles mid-FETCH → mem_req_valid and mem_req_addr stable throughout; no skipped or duplicate addresses.
- No responses for 20 cycles on an 8×8 map with MAX_OUT=4 → exactly 4 requests issued, then stall; the load resumes as responses return.
- Base address 0xFFFE with a 4×4 map → requests to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- rst_n pulsed low in FETCH with 2 reads outstanding → IDLE with cmd_ready=1; late responses produce no bld_en; with FMAP_LOAD_ERR_EN, an m=0 command yields done=1 and err=1, with no mem_req_valid.
